// File: rtl/creek_instr_fetch.sv
// creek_instr_fetch: core-side reader of the dual-port instruction memory.
// Sequences the PC, absorbs the 1-cycle memory read latency with a 2-entry
// skid buffer, delivers instructions over valid/ready, and implements the
// core end of the creek control protocol (pause_n, resume, waiting,
// local_init_done).
// Optional build macro: CREEK_FETCH_PERF_EN adds perf_fetched/perf_stall
// saturating counters.
module creek_instr_fetch #(
    parameter int unsigned           ADDR_WIDTH  = 10,
    parameter int unsigned           INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   local_init_done,
    input  logic                   pause_n,
    input  logic                   resume,
    output logic                   waiting,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rden,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   br_valid,
    input  logic [ADDR_WIDTH-1:0]  br_target,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc
`ifdef CREEK_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_HALTED
    } state_t;

    state_t                 state;
    logic                   waiting_q;
    logic                   halt_pending;

    logic [ADDR_WIDTH-1:0]  pc;
    logic                   inflight;
    logic [ADDR_WIDTH-1:0]  inflight_pc;

    // Skid buffer: entry 0 is always the head
    logic [1:0]             count;
    logic [INSTR_WIDTH-1:0] b0_data, b1_data;
    logic [ADDR_WIDTH-1:0]  b0_pc, b1_pc;

    logic [1:0]             ncount;
    logic [INSTR_WIDTH-1:0] nb0_data, nb1_data;
    logic [ADDR_WIDTH-1:0]  nb0_pc, nb1_pc;

    logic                   active;
    logic                   ret_live;
    logic                   ret_is_halt;
    logic                   ret_valid;
    logic                   halt_ret;
    logic                   pop;
    logic                   issue;
    logic                   resume_go;
    logic                   halt_next;
    logic                   halt_done;
    logic [2:0]             demand;
    logic [2:0]             room;

    // Return-path classification and handshake / issue decisions
    always_comb begin
        active      = (state == S_RUN) || (state == S_PAUSED);
        // Returns after a halt word, or after leaving RUN/PAUSED, are discarded
        ret_live    = inflight && active && !halt_pending;
        ret_is_halt = (mem_data[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
        ret_valid   = ret_live && !ret_is_halt;
        halt_ret    = ret_live && ret_is_halt;

        // An empty buffer exposes the returning word directly so the first
        // instruction is visible the same cycle it leaves the memory
        instr_valid = (count != 2'd0) || ret_valid;
        pop         = instr_valid && instr_ready;

        demand      = {1'b0, count} + {2'b00, inflight};
        room        = 3'd2 + {2'b00, pop};
        issue       = (state == S_RUN) && pause_n && !br_valid && !halt_pending
                      && (demand < room);

        resume_go   = ((state == S_IDLE) || (state == S_HALTED))
                      && resume && local_init_done && !br_valid;
        halt_next   = (halt_pending || halt_ret) && !br_valid && !resume_go;
    end

    // Memory request outputs
    always_comb begin
        mem_rden = issue;
        mem_addr = issue ? pc : '0;
    end

    // Head-of-buffer presentation to decode
    always_comb begin
        if (count != 2'd0) begin
            instr_data = b0_data;
            instr_pc   = b0_pc;
        end else if (ret_valid) begin
            instr_data = mem_data;
            instr_pc   = inflight_pc;
        end else begin
            instr_data = '0;
            instr_pc   = '0;
        end
    end

    // Next buffer contents: pop the head, then append the returning word
    always_comb begin
        nb0_data = b0_data;
        nb0_pc   = b0_pc;
        nb1_data = b1_data;
        nb1_pc   = b1_pc;
        ncount   = count;
        if (pop && (count != 2'd0)) begin
            nb0_data = b1_data;
            nb0_pc   = b1_pc;
            ncount   = count - 2'd1;
        end
        // A word consumed straight from the return path is never stored
        if (ret_valid && !(pop && (count == 2'd0))) begin
            if (ncount == 2'd0) begin
                nb0_data = mem_data;
                nb0_pc   = inflight_pc;
            end else begin
                nb1_data = mem_data;
                nb1_pc   = inflight_pc;
            end
            ncount = ncount + 2'd1;
        end
        if (br_valid) begin
            ncount = '0;
        end
        halt_done = halt_next && (ncount == 2'd0) && (state == S_RUN) && pause_n;
    end

    // Control FSM with registered waiting flag and halt tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            waiting_q    <= 1'b1;
            halt_pending <= 1'b0;
        end else begin
            halt_pending <= halt_done ? 1'b0 : halt_next;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (resume_go) begin
                        state     <= pause_n ? S_RUN : S_PAUSED;
                        waiting_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!pause_n) begin
                        state <= S_PAUSED;
                    end else if (halt_done) begin
                        state     <= S_HALTED;
                        waiting_q <= 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (pause_n) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    waiting_q <= 1'b1;
                end
            endcase
        end
    end

    assign waiting = waiting_q;

    // PC sequencing, in-flight tracking and skid buffer storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= START_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            b0_data     <= '0;
            b0_pc       <= '0;
            b1_data     <= '0;
            b1_pc       <= '0;
        end else begin
            if (br_valid) begin
                pc <= br_target;
            end else if (resume_go) begin
                pc <= START_PC;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            count   <= resume_go ? 2'd0 : ncount;
            b0_data <= nb0_data;
            b0_pc   <= nb0_pc;
            b1_data <= nb1_data;
            b1_pc   <= nb1_pc;
        end
    end

`ifdef CREEK_FETCH_PERF_EN
    // Saturating counters of accepted instructions and decode stalls in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (resume_go) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == S_RUN) && instr_valid && !instr_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/creek_instr_fetch.md
Name: creek_instr_fetch

Overview:
- Core-side reader of the dual-port instruction memory that the Nios fills over its instruction write port.
- Sequences the read address (PC) and absorbs the memory's 1-cycle read latency with a 2-entry skid buffer.
- Delivers instructions to decode over a valid/ready handshake.
- Implements the core end of the creek control protocol: pause_n, resume, waiting, local_init_done.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width (PC width).
- INSTR_WIDTH, 16, instruction word width.
- START_PC, 0, PC loaded on every resume.
- HALT_OPCODE, 4'hF, value of instr[INSTR_WIDTH-1 -: 4] that marks a halt instruction.

Ports:
- clk  in  1  core clock, shared with instruction memory.
- reset  in  1  asynchronous, active-high reset.
- local_init_done  in  1  memory subsystem ready; fetch never leaves IDLE while low.
- pause_n  in  1  low requests pause; PC is held.
- resume  in  1  single-cycle pulse; starts fetch at START_PC.
- waiting  out  1  high in IDLE and HALTED.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rden  out  1  read issued this cycle; data returns next cycle.
- mem_data  in  INSTR_WIDTH  read data, valid the cycle after mem_rden.
- br_valid  in  1  redirect request from execute.
- br_target  in  ADDR_WIDTH  redirect PC.
- instr_valid  out  1  instr_data/instr_pc valid.
- instr_ready  in  1  decode accepts when valid&ready.
- instr_data  out  INSTR_WIDTH  instruction at head of buffer.
- instr_pc  out  ADDR_WIDTH  address of instr_data.

Behaviour:
- Reset values:
  - state=IDLE, waiting=1, pc=START_PC.
  - mem_rden=0, mem_addr=0, instr_valid=0, instr_data=0, instr_pc=0.
  - Buffer empty, in-flight flag=0.
- States:
  - IDLE -> RUN on resume & local_init_done. pc<=START_PC, buffer flushed.
  - RUN -> PAUSED when pause_n=0.
  - PAUSED -> RUN when pause_n=1.
  - RUN -> HALTED when a halt word returns and all older buffered entries have been accepted.
  - HALTED -> RUN on resume, same actions as leaving IDLE.
  - resume outside IDLE/HALTED is ignored.
- Issue rule:
  - mem_rden=1 in RUN when (occupancy + inflight - pop) < 2, where pop = instr_valid & instr_ready this cycle.
  - Never issue in PAUSED, IDLE or HALTED.
  - On issue: mem_addr=pc, pc<=pc+1 modulo 2^ADDR_WIDTH (wraps from max to 0).
- Return:
  - The cycle after an issue, {mem_data, issued pc} is pushed to the buffer.
  - A read in flight at pause entry still completes and is buffered.
  - Buffer contents and the valid handshake continue to operate while PAUSED.
- Throughput: with instr_ready held high, one instruction per cycle.
- Latency: first instr_valid appears 2 cycles after the resume cycle.
- Halt:
  - A returned word with the HALT_OPCODE field is not pushed.
  - The following in-flight read is discarded and issuing stops.
  - waiting rises the cycle after the buffer empties.
- Redirect (br_valid=1):
  - Highest priority after reset.
  - Same cycle: buffer cleared, in-flight return marked discard, no issue.
  - pc<=br_target.
  - Next cycle (if RUN): issue at br_target.
  - instr_valid=0 the cycle after br_valid.
  - br_valid in IDLE/HALTED only loads pc; the next resume still overrides it with START_PC.
- Simultaneous events:
  - br_valid with pop: the pop completes and the buffer is still flushed.
  - resume with pause_n=0 from IDLE: go to PAUSED with pc=START_PC.
  - pause_n=0 with br_valid: pc is redirected and the block goes to PAUSED.
- instr_data/instr_pc hold stable while instr_valid & ~instr_ready.
- Asynchronous reset mid-operation forces all reset values immediately; in-flight data is dropped.

Optional Feature:
- Macro: CREEK_FETCH_PERF_EN.
- When defined, the block adds outputs perf_fetched[31:0] and perf_stall[31:0]:
  - perf_fetched counts accepted instructions.
  - perf_stall counts cycles in RUN with instr_valid & ~instr_ready.
  - Both clear on reset and on resume, and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, local_init_done=1, resume pulse, ready=1, mem[0..3]=0x1001,0x1002,0x1003,0xF000 -> mem_rden at cycle 1; instr_valid from cycle 2; 0x1001/0x1002/0x1003 with pc 0,1,2 on consecutive cycles; 0xF000 not delivered; waiting=1 two cycles after the last accept.
- ready toggling 1,0,0,1 during streaming -> no lost or duplicated words; data/pc stable while stalled; buffer never exceeds 2; mem_rden suppressed when full.
- pause_n low for 5 cycles mid-stream at pc=6 -> no mem_rden while low; buffered words still deliverable; first issue after release is address 6 (or 7 if 6 was in flight).
- br_valid with br_target=0x3F0 while 2 entries are buffered -> instr_valid=0 next cycle; next delivered pc=0x3F0; stale words never appear.
- Program with no halt starting at pc 0x3FE -> delivered pcs 0x3FE, 0x3FF, 0x000, 0x001.
- Resume held with local_init_done=0 -> stays IDLE with waiting=1; reset asserted mid-RUN -> outputs return to reset values asynchronously.
